// File: rtl/sync_arith_result_collector_pkg.sv
// Shared definitions for the arithmetic-unit result collector: widths,
// the FIFO entry layout and a saturating increment helper.
package sync_arith_pkg;

  localparam int STATUS_W      = 4;
  localparam int DEFAULT_BITS  = 32;
  localparam int DEFAULT_DEPTH = 8;
  localparam int DROP_W        = 16;

  // One captured result/status pair as emitted by the arithmetic unit.
  typedef struct packed {
    logic [DEFAULT_BITS-1:0] result;
    logic [STATUS_W-1:0]     status;
  } arith_entry_t;

  // Increment a drop count, holding at all-ones instead of wrapping.
  function automatic logic [DROP_W-1:0] sat_inc_drop(input logic [DROP_W-1:0] value);
    logic [DROP_W-1:0] next_value;
    if (value == {DROP_W{1'b1}}) begin
      next_value = value;
    end else begin
      next_value = value + {{(DROP_W-1){1'b0}}, 1'b1};
    end
    return next_value;
  endfunction

endpackage

// File: rtl/sync_arith_result_collector_if.sv
// Bus between the arithmetic unit / consumer side and the result collector.
// The slave modport is the collector; the master modport is whoever drives
// the unit results and consumes the FIFO head.
interface sync_arith_result_collector_if
  import sync_arith_pkg::*;
#(
  parameter int BITS  = DEFAULT_BITS,
  parameter int DEPTH = DEFAULT_DEPTH
);

  // Producer side (arithmetic unit outputs)
  logic                    i_valid;
  logic [BITS-1:0]         i_result;
  logic [STATUS_W-1:0]     i_status;
  logic                    i_clear_sticky;

  // Consumer handshake and FIFO head
  logic                    i_ready;
  logic                    o_valid;
  logic [BITS-1:0]         o_result;
  logic [STATUS_W-1:0]     o_status;

  // Occupancy and monitoring
  logic [$clog2(DEPTH):0]  o_count;
  logic                    o_full;
  logic                    o_empty;
  logic [STATUS_W-1:0]     o_sticky_status;
  logic [DROP_W-1:0]       o_dropped;

  modport slave (
    input  i_valid, i_result, i_status, i_clear_sticky, i_ready,
    output o_valid, o_result, o_status, o_count, o_full, o_empty,
           o_sticky_status, o_dropped
  );

  modport master (
    output i_valid, i_result, i_status, i_clear_sticky, i_ready,
    input  o_valid, o_result, o_status, o_count, o_full, o_empty,
           o_sticky_status, o_dropped
  );

endinterface

// File: rtl/sync_arith_fifo.sv
// Generic show-ahead FIFO: storage, wrapping pointers and occupancy count.
// The caller is responsible for never pushing into a full FIFO unless it
// pops in the same cycle. The head is forced to zero while empty so that
// stale storage never reaches the outputs.
module sync_arith_fifo
  import sync_arith_pkg::*;
#(
  parameter int  DEPTH   = DEFAULT_DEPTH,
  parameter type entry_t = arith_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  entry_t           i_wdata,
  output entry_t           o_rdata,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next pointer and occupancy values; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (i_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({i_push, i_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers, cleared asynchronously.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because the head is masked when empty.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      mem_q[wr_ptr_q] <= i_wdata;
    end
  end

  // Head entry and occupancy flags, all derived from registered state only.
  always_comb begin
    o_rdata = '0;
    o_count = count_q;
    o_full  = (count_q == CNT_W'(DEPTH));
    o_empty = (count_q == CNT_W'(0));
    if (count_q == CNT_W'(0)) begin
      o_rdata = '0;
    end else begin
      o_rdata = mem_q[rd_ptr_q];
    end
  end

endmodule

// File: rtl/sync_arith_result_collector.sv
// Receive-side collector for the synchronous arithmetic unit. Every valid
// result/status pair is queued for a downstream valid/ready consumer. The
// unit cannot be stalled, so overflows are counted rather than
// back-pressured, and all seen status bits are accumulated as sticky flags.
module sync_arith_result_collector
  import sync_arith_pkg::*;
#(
  parameter int BITS  = DEFAULT_BITS,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input logic                          i_clk,
  input logic                          i_reset,
  sync_arith_result_collector_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Entry layout matching arith_entry_t but following the BITS parameter.
  typedef struct packed {
    logic [BITS-1:0]     result;
    logic [STATUS_W-1:0] status;
  } entry_t;

  logic                push_s;
  logic                pop_s;
  logic                drop_s;
  entry_t              wr_entry_s;
  entry_t              head_s;
  logic [CNT_W-1:0]    count_s;
  logic                full_s;
  logic                empty_s;

  logic [STATUS_W-1:0] sticky_q, sticky_d;
  logic [DROP_W-1:0]   dropped_q, dropped_d;

  // Handshake qualification: a full FIFO still accepts when the head leaves the same cycle.
  always_comb begin
    pop_s             = (!empty_s) && bus.i_ready;
    push_s            = bus.i_valid && ((!full_s) || pop_s);
    drop_s            = bus.i_valid && full_s && (!pop_s);
    wr_entry_s        = '0;
    wr_entry_s.result = bus.i_result;
    wr_entry_s.status = bus.i_status;
  end

  sync_arith_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (push_s),
    .i_pop   (pop_s),
    .i_wdata (wr_entry_s),
    .o_rdata (head_s),
    .o_count (count_s),
    .o_full  (full_s),
    .o_empty (empty_s)
  );

  // Sticky status and drop counter next state; new data wins over a clear.
  always_comb begin
    sticky_d  = sticky_q;
    dropped_d = dropped_q;
    if (bus.i_clear_sticky) begin
      if (bus.i_valid) begin
        sticky_d = bus.i_status;
      end else begin
        sticky_d = {STATUS_W{1'b0}};
      end
    end else if (bus.i_valid) begin
      sticky_d = sticky_q | bus.i_status;
    end else begin
      sticky_d = sticky_q;
    end
    if (drop_s) begin
      dropped_d = sat_inc_drop(dropped_q);
    end else begin
      dropped_d = dropped_q;
    end
  end

  // Monitoring registers, cleared asynchronously with the FIFO.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sticky_q  <= {STATUS_W{1'b0}};
      dropped_q <= {DROP_W{1'b0}};
    end else begin
      sticky_q  <= sticky_d;
      dropped_q <= dropped_d;
    end
  end

  assign bus.o_valid         = !empty_s;
  assign bus.o_result        = head_s.result;
  assign bus.o_status        = head_s.status;
  assign bus.o_count         = count_s;
  assign bus.o_full          = full_s;
  assign bus.o_empty         = empty_s;
  assign bus.o_sticky_status = sticky_q;
  assign bus.o_dropped       = dropped_q;

endmodule

// File: tb/tb_sync_arith_result_collector.sv
// Self-checking bench for sync_arith_result_collector. A queue-based
// reference model tracks the expected FIFO contents, drop count and sticky
// flags from the behavioural rules; each scenario task checks inline.
module tb_sync_arith_result_collector;
  import sync_arith_pkg::*;

  localparam int BITS  = 32;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sync_arith_result_collector_if #(.BITS(BITS), .DEPTH(DEPTH)) bus ();

  sync_arith_result_collector #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int tests_run = 0;
  int fails     = 0;

  // Reference model state
  logic [35:0] mq [$];
  int          m_dropped;
  logic [3:0]  m_sticky;
  int          n_push_req;
  int          n_pop;
  int          n_accept;

  task automatic model_reset();
    mq.delete();
    m_dropped  = 0;
    m_sticky   = 4'b0000;
    n_push_req = 0;
    n_pop      = 0;
    n_accept   = 0;
  endtask

  // Apply one cycle of inputs and advance the model across the clock edge.
  task automatic drive(input logic v, input logic [31:0] r, input logic [3:0] s,
                       input logic clr, input logic rdy);
    bit pop;
    bit acc;
    bus.i_valid        = v;
    bus.i_result       = r;
    bus.i_status       = s;
    bus.i_clear_sticky = clr;
    bus.i_ready        = rdy;
    pop = (mq.size() > 0) && rdy;
    acc = v && ((mq.size() < DEPTH) || pop);
    @(posedge clk);
    if (pop) begin
      void'(mq.pop_front());
      n_pop++;
    end
    if (acc) begin
      mq.push_back({r, s});
      n_accept++;
    end else if (v && (m_dropped < 65535)) begin
      m_dropped++;
    end
    if (v) n_push_req++;
    if (clr) m_sticky = v ? s : 4'b0000;
    else if (v) m_sticky = m_sticky | s;
    #1;
  endtask

  task automatic test_reset();
    bus.i_valid = 1'b0; bus.i_result = 32'd0; bus.i_status = 4'd0;
    bus.i_clear_sticky = 1'b0; bus.i_ready = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b1, 32'h0000_00AA, 4'h3, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_00BB, 4'h1, 1'b0, 1'b0);
    // Assert reset between edges; outputs must clear without a clock.
    #2 rst = 1'b1;
    #1;
    model_reset();
    tests_run++;
    if (bus.o_valid !== 1'b0 || bus.o_result !== 32'd0 || bus.o_status !== 4'd0 ||
        bus.o_count !== 4'd0 || bus.o_full !== 1'b0 || bus.o_empty !== 1'b1 ||
        bus.o_sticky_status !== 4'd0 || bus.o_dropped !== 16'd0) begin
      fails++;
      $display("FAIL reset_async: got valid=%b res=%0h st=%0h cnt=%0d full=%b empty=%b sticky=%0h drop=%0d, expected 0/0/0/0/0/1/0/0",
               bus.o_valid, bus.o_result, bus.o_status, bus.o_count, bus.o_full,
               bus.o_empty, bus.o_sticky_status, bus.o_dropped);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0);
    tests_run++;
    if (bus.o_empty !== 1'b1 || bus.o_count !== 4'd0) begin
      fails++;
      $display("FAIL reset_idle: got empty=%b count=%0d, expected empty=1 count=0",
               bus.o_empty, bus.o_count);
    end
  endtask

  task automatic test_single();
    drive(1'b1, 32'd7, 4'b0010, 1'b0, 1'b0);
    tests_run++;
    if (bus.o_valid !== 1'b1 || bus.o_result !== 32'd7 || bus.o_status !== 4'b0010 ||
        bus.o_count !== 4'd1) begin
      fails++;
      $display("FAIL single_push: got valid=%b res=%0d st=%0h cnt=%0d, expected 1/7/2/1",
               bus.o_valid, bus.o_result, bus.o_status, bus.o_count);
    end
    drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b1);
    tests_run++;
    if (bus.o_empty !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_result !== 32'd0) begin
      fails++;
      $display("FAIL single_pop: got empty=%b valid=%b res=%0h, expected 1/0/0",
               bus.o_empty, bus.o_valid, bus.o_result);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 32'(i), 4'(i), 1'b0, 1'b0);
      if (i == 8) begin
        tests_run++;
        if (bus.o_full !== 1'b1 || bus.o_count !== 4'd8) begin
          fails++;
          $display("FAIL fill_full: got full=%b count=%0d, expected full=1 count=8",
                   bus.o_full, bus.o_count);
        end
      end
    end
    tests_run++;
    if (bus.o_dropped !== 16'd2 || bus.o_count !== 4'd8) begin
      fails++;
      $display("FAIL overflow_drop: got dropped=%0d count=%0d, expected dropped=2 count=8",
               bus.o_dropped, bus.o_count);
    end
    for (int k = 1; k <= 8; k++) begin
      tests_run++;
      if (bus.o_valid !== 1'b1 || bus.o_result !== 32'(k)) begin
        fails++;
        $display("FAIL fill_drain: got valid=%b res=%0d, expected valid=1 res=%0d",
                 bus.o_valid, bus.o_result, k);
      end
      drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b1);
    end
    tests_run++;
    if (bus.o_empty !== 1'b1) begin
      fails++;
      $display("FAIL fill_empty: got empty=%b, expected 1", bus.o_empty);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 1; i <= 8; i++) drive(1'b1, 32'(i), 4'(i), 1'b0, 1'b0);
    drive(1'b1, 32'd9, 4'd9, 1'b0, 1'b1);
    tests_run++;
    if (bus.o_count !== 4'd8 || bus.o_full !== 1'b1 || bus.o_dropped !== 16'd2) begin
      fails++;
      $display("FAIL full_push_pop: got count=%0d full=%b dropped=%0d, expected 8/1/2",
               bus.o_count, bus.o_full, bus.o_dropped);
    end
    for (int k = 2; k <= 9; k++) begin
      tests_run++;
      if (bus.o_valid !== 1'b1 || bus.o_result !== 32'(k)) begin
        fails++;
        $display("FAIL full_drain: got valid=%b res=%0d, expected valid=1 res=%0d",
                 bus.o_valid, bus.o_result, k);
      end
      drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_sticky();
    drive(1'b0, 32'd0, 4'd0, 1'b1, 1'b1);
    tests_run++;
    if (bus.o_sticky_status !== 4'b0000) begin
      fails++;
      $display("FAIL sticky_initial_clear: got %b, expected 0000", bus.o_sticky_status);
    end
    drive(1'b1, 32'd11, 4'b0001, 1'b0, 1'b1);
    drive(1'b1, 32'd12, 4'b0100, 1'b0, 1'b1);
    tests_run++;
    if (bus.o_sticky_status !== 4'b0101) begin
      fails++;
      $display("FAIL sticky_or: got %b, expected 0101", bus.o_sticky_status);
    end
    drive(1'b1, 32'd13, 4'b1000, 1'b1, 1'b1);
    tests_run++;
    if (bus.o_sticky_status !== 4'b1000) begin
      fails++;
      $display("FAIL sticky_clear_with_data: got %b, expected 1000", bus.o_sticky_status);
    end
    drive(1'b0, 32'd0, 4'd0, 1'b1, 1'b1);
    tests_run++;
    if (bus.o_sticky_status !== 4'b0000) begin
      fails++;
      $display("FAIL sticky_clear_alone: got %b, expected 0000", bus.o_sticky_status);
    end
    repeat (4) drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic        v, clr, rdy;
    logic [31:0] r;
    logic [3:0]  s;
    logic [35:0] exp_head;
    int          err_prints;
    err_prints = 0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      v   = ($urandom_range(0, 15) != 0);
      r   = $urandom;
      s   = 4'($urandom_range(0, 15));
      clr = ($urandom_range(0, 31) == 0);
      rdy = ($urandom_range(0, 7) != 0);
      drive(v, r, s, clr, rdy);
      exp_head = (mq.size() > 0) ? mq[0] : 36'd0;
      tests_run++;
      if (bus.o_valid !== (mq.size() > 0) ||
          {bus.o_result, bus.o_status} !== exp_head ||
          bus.o_count !== 4'(mq.size()) ||
          bus.o_full !== (mq.size() == DEPTH) ||
          bus.o_empty !== (mq.size() == 0) ||
          bus.o_sticky_status !== m_sticky ||
          bus.o_dropped !== 16'(m_dropped)) begin
        fails++;
        if (err_prints < 20) begin
          err_prints++;
          $display("FAIL random_cycle%0d: got v=%b head=%h cnt=%0d f=%b e=%b sticky=%h drop=%0d, expected v=%b head=%h cnt=%0d sticky=%h drop=%0d",
                   c, bus.o_valid, {bus.o_result, bus.o_status}, bus.o_count, bus.o_full,
                   bus.o_empty, bus.o_sticky_status, bus.o_dropped, (mq.size() > 0),
                   exp_head, mq.size(), m_sticky, m_dropped);
        end
      end
    end
    tests_run++;
    if (int'(bus.o_count) + int'(bus.o_dropped) !== n_push_req - n_pop) begin
      fails++;
      $display("FAIL random_conservation: got count+dropped=%0d, expected pushed-popped=%0d",
               int'(bus.o_count) + int'(bus.o_dropped), n_push_req - n_pop);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_sticky();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded 500000 time units");
    $fatal(1);
  end

endmodule
